// File: rtl/dice_turn_ctrl_pkg.sv
// Shared types for the dice turn controller: FSM states, winner codes and die-face bounds.
package dice_turn_ctrl_pkg;

  localparam int unsigned DIE_W = 3;
  localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
  localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

  typedef enum logic [2:0] {
    P1_TURN   = 3'd0,
    P1_ADD    = 3'd1,
    P2_TURN   = 3'd2,
    P2_ADD    = 3'd3,
    GAME_OVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  function automatic logic die_valid(input logic [DIE_W-1:0] face);
    return (face >= DIE_MIN) && (face <= DIE_MAX);
  endfunction

endpackage

// File: rtl/dice_turn_ctrl_key_debounce.sv
// Synchroniser, debounce counter and press (debounced 1->0) pulse for one raw active-low key.
module dice_turn_ctrl_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_deb;
  logic             r_armed;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sync;

  assign w_sync  = r_sync[1];
  assign o_press = r_press;

  // Armed only after a released level is seen, so a key held through reset never presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_deb   <= 1'b1;
      r_armed <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (w_sync) r_armed <= 1'b1;
      if (w_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_deb   <= w_sync;
        r_cnt   <= '0;
        r_press <= r_armed & ~w_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dice_turn_ctrl.sv
// Two-player roll controller: debounced keys, alternating turns, saturating scores, end-of-game detect.
module dice_turn_ctrl
  import dice_turn_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned TARGET_SCORE    = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key1_n,
  input  logic               key2_n,
  input  logic [DIE_W-1:0]   die1,
  input  logic [DIE_W-1:0]   die2,
  output logic               roll1,
  output logic               roll2,
  output logic [SCORE_W-1:0] cnt1,
  output logic [SCORE_W-1:0] cnt2,
  output logic               turn,
  output logic               end_of_game,
  output logic [1:0]         winner,
  output logic               invalid_roll
);

  localparam logic [SCORE_W:0] TARGET = (SCORE_W+1)'(TARGET_SCORE);

  state_e             r_state, w_state_nxt;
  winner_e            r_winner, w_winner_nxt;
  logic [DIE_W-1:0]   r_roll_val, w_roll_val_nxt;
  logic [SCORE_W-1:0] r_cnt1, w_cnt1_nxt, r_cnt2, w_cnt2_nxt;
  logic               r_turn, w_turn_nxt, r_eog, w_eog_nxt;
  logic               r_roll1, w_roll1_nxt, r_roll2, w_roll2_nxt;
  logic               r_invalid, w_invalid_nxt;
  logic               w_press1, w_press2;
  logic [SCORE_W-1:0] w_add_base, w_sat;
  logic [SCORE_W:0]   w_sum;
  logic               w_reach;

  dice_turn_ctrl_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk(clk), .rst_n(reset), .i_key_n(key1_n), .o_press(w_press1)
  );

  dice_turn_ctrl_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
    .clk(clk), .rst_n(reset), .i_key_n(key2_n), .o_press(w_press2)
  );

  // One shared saturating adder serves whichever player is in its ADD cycle.
  assign w_add_base = (r_state == P2_ADD) ? r_cnt2 : r_cnt1;
  assign w_sum      = {1'b0, w_add_base} + (SCORE_W+1)'(r_roll_val);
  assign w_sat      = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
  assign w_reach    = ({1'b0, w_sat} >= TARGET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= P1_TURN;
      r_winner   <= WIN_NONE;
      r_roll_val <= '0;
      r_cnt1     <= '0;
      r_cnt2     <= '0;
      r_turn     <= 1'b0;
      r_eog      <= 1'b0;
      r_roll1    <= 1'b0;
      r_roll2    <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_winner   <= w_winner_nxt;
      r_roll_val <= w_roll_val_nxt;
      r_cnt1     <= w_cnt1_nxt;
      r_cnt2     <= w_cnt2_nxt;
      r_turn     <= w_turn_nxt;
      r_eog      <= w_eog_nxt;
      r_roll1    <= w_roll1_nxt;
      r_roll2    <= w_roll2_nxt;
      r_invalid  <= w_invalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_winner_nxt   = r_winner;
    w_roll_val_nxt = r_roll_val;
    w_cnt1_nxt     = r_cnt1;
    w_cnt2_nxt     = r_cnt2;
    w_turn_nxt     = r_turn;
    w_eog_nxt      = r_eog;
    w_roll1_nxt    = 1'b0;
    w_roll2_nxt    = 1'b0;
    w_invalid_nxt  = 1'b0;
    case (r_state)
      P1_TURN: begin
        if (w_press1) begin
          w_roll1_nxt    = 1'b1;
          w_roll_val_nxt = die1;
          w_state_nxt    = P1_ADD;
        end
      end
      P1_ADD: begin
        if (die_valid(r_roll_val)) begin
          w_cnt1_nxt = w_sat;
          if (w_reach) begin
            w_state_nxt  = GAME_OVER;
            w_eog_nxt    = 1'b1;
            w_winner_nxt = WIN_P1;
          end else begin
            w_state_nxt = P2_TURN;
            w_turn_nxt  = 1'b1;
          end
        end else begin
          w_invalid_nxt = 1'b1;
          w_state_nxt   = P1_TURN;
        end
      end
      P2_TURN: begin
        if (w_press2) begin
          w_roll2_nxt    = 1'b1;
          w_roll_val_nxt = die2;
          w_state_nxt    = P2_ADD;
        end
      end
      P2_ADD: begin
        if (die_valid(r_roll_val)) begin
          w_cnt2_nxt = w_sat;
          if (w_reach) begin
            w_state_nxt  = GAME_OVER;
            w_eog_nxt    = 1'b1;
            w_winner_nxt = WIN_P2;
          end else begin
            w_state_nxt = P1_TURN;
            w_turn_nxt  = 1'b0;
          end
        end else begin
          w_invalid_nxt = 1'b1;
          w_state_nxt   = P2_TURN;
        end
      end
      GAME_OVER: begin
        w_state_nxt = GAME_OVER;
      end
      default: begin
        w_state_nxt = P1_TURN;
      end
    endcase
  end

  assign roll1        = r_roll1;
  assign roll2        = r_roll2;
  assign cnt1         = r_cnt1;
  assign cnt2         = r_cnt2;
  assign turn         = r_turn;
  assign end_of_game  = r_eog;
  assign winner       = r_winner;
  assign invalid_roll = r_invalid;

endmodule
